// File: rtl/rx_blocklock_descrambler.sv
// 64b/66b receive front end: sync-header block lock with gearbox slip control,
// x^58+x^39+1 self-synchronising descrambler and hi-BER monitoring.
module rx_blocklock_descrambler #(
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 64,
  parameter int BAD_LIMIT  = 16,
  parameter int SLIP_WAIT  = 32,
  parameter int BER_WINDOW = 19531,
  parameter int BER_LIMIT  = 16
) (
  input  logic        RX_CLK,
  input  logic        S_ARESETN,
  input  logic        i_valid,
  input  logic [65:0] i_data,
  output logic        o_slip,
  output logic        RX_VALID,
  output logic [65:0] RX_DATA,
  output logic        o_block_lock,
  output logic        o_hi_ber,
  output logic        o_phy_fault
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int HW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);
  localparam int TW = $clog2(BER_WINDOW + 1);
  localparam int CW = $clog2(BER_LIMIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [HW-1:0] HDR_LAST  = HW'(WINDOW - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_LIMIT - 1);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);
  localparam logic [TW-1:0] BER_LAST  = TW'(BER_WINDOW - 1);
  localparam logic [CW-1:0] BER_MAX   = CW'(BER_LIMIT);

  typedef enum logic [1:0] {HUNT, SLIPWAIT, LOCKED} state_t;

  state_t        state;
  logic [GW-1:0] good_cnt;
  logic [HW-1:0] hdr_cnt;
  logic [BW-1:0] bad_cnt;
  logic [SW-1:0] slip_cnt;
  logic [TW-1:0] ber_timer;
  logic [CW-1:0] ber_cnt;
  logic [57:0]   scr_state;

  logic          hdr_ok;
  logic          hdr_bad;
  logic          gain_lock;
  logic          lose_lock;
  logic          lock_next;
  logic          hi_ber_next;
  logic          ber_end;
  logic [CW-1:0] ber_cnt_inc;
  logic [121:0]  scr_x;
  logic [63:0]   desc;

  assign hdr_ok  = i_data[1] ^ i_data[0];
  assign hdr_bad = ~hdr_ok;

  assign gain_lock = i_valid && (state == HUNT) && hdr_ok && (good_cnt == GOOD_LAST);
  assign lose_lock = i_valid && (state == LOCKED) && hdr_bad && (bad_cnt == BAD_LAST);
  assign lock_next = gain_lock || (o_block_lock && !lose_lock);

  assign ber_end     = (ber_timer == BER_LAST);
  assign ber_cnt_inc = (hdr_bad && (ber_cnt != BER_MAX)) ? ber_cnt + 1'b1 : ber_cnt;

  // Window end re-evaluates the flag; mid-window it can only be raised.
  always_comb begin
    hi_ber_next = o_hi_ber;
    if (!lock_next) begin
      hi_ber_next = 1'b0;
    end else if (i_valid && (state == LOCKED)) begin
      if (ber_end) begin
        hi_ber_next = (ber_cnt_inc >= BER_MAX);
      end else if (ber_cnt_inc >= BER_MAX) begin
        hi_ber_next = 1'b1;
      end
    end
  end

  // x[k] for k<58 is history (s[0] oldest), x[k+58] is current payload bit k.
  assign scr_x = {i_data[65:2], scr_state};

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_desc
      assign desc[gi] = scr_x[gi + 58] ^ scr_x[gi + 19] ^ scr_x[gi];
    end
  endgenerate

  always_ff @(posedge RX_CLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      state        <= HUNT;
      good_cnt     <= '0;
      hdr_cnt      <= '0;
      bad_cnt      <= '0;
      slip_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_hi_ber     <= 1'b0;
      o_phy_fault  <= 1'b1;
    end else begin
      o_slip       <= 1'b0;
      o_block_lock <= lock_next;
      o_hi_ber     <= hi_ber_next;
      o_phy_fault  <= !lock_next || hi_ber_next;
      if (i_valid) begin
        case (state)
          HUNT: begin
            if (hdr_ok) begin
              if (gain_lock) begin
                state    <= LOCKED;
                good_cnt <= '0;
                hdr_cnt  <= '0;
                bad_cnt  <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              o_slip   <= 1'b1;
              good_cnt <= '0;
              slip_cnt <= '0;
              state    <= SLIPWAIT;
            end
          end
          SLIPWAIT: begin
            if (slip_cnt == SLIP_LAST) begin
              slip_cnt <= '0;
              state    <= HUNT;
            end else begin
              slip_cnt <= slip_cnt + 1'b1;
            end
          end
          LOCKED: begin
            // The error that reaches the limit wins over a window boundary.
            if (lose_lock) begin
              o_slip   <= 1'b1;
              hdr_cnt  <= '0;
              bad_cnt  <= '0;
              slip_cnt <= '0;
              state    <= SLIPWAIT;
            end else if (hdr_cnt == HDR_LAST) begin
              hdr_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
              bad_cnt <= bad_cnt + BW'(hdr_bad);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge RX_CLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
    end else if (!lock_next) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
    end else if (i_valid && (state == LOCKED)) begin
      if (ber_end) begin
        ber_timer <= '0;
        ber_cnt   <= '0;
      end else begin
        ber_timer <= ber_timer + 1'b1;
        ber_cnt   <= ber_cnt_inc;
      end
    end
  end

  // Descrambler history advances on every valid word so it is primed at lock.
  always_ff @(posedge RX_CLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      RX_VALID  <= 1'b0;
      RX_DATA   <= '0;
      scr_state <= '0;
    end else begin
      RX_VALID <= i_valid && (state == LOCKED);
      if (i_valid) begin
        RX_DATA   <= {desc, i_data[1:0]};
        scr_state <= i_data[65:8];
      end
    end
  end

endmodule

// File: tb/tb_rx_blocklock_descrambler.sv
// Directed bench for rx_blocklock_descrambler: a bit-serial scrambler feeds the DUT,
// expected beats go to a queue and a monitor compares each RX_VALID beat.
module tb_rx_blocklock_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [65:0] i_data;
  logic        o_slip;
  logic        rx_valid;
  logic [65:0] rx_data;
  logic        o_block_lock;
  logic        o_hi_ber;
  logic        o_phy_fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [65:0] exp_q[$];
  logic [57:0] tx_hist = '0;  // [0] = most recently transmitted scrambled bit
  logic [31:0] wcnt = '0;

  always #5 clk = ~clk;

  rx_blocklock_descrambler dut (
    .RX_CLK      (clk),
    .S_ARESETN   (rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_slip      (o_slip),
    .RX_VALID    (rx_valid),
    .RX_DATA     (rx_data),
    .o_block_lock(o_block_lock),
    .o_hi_ber    (o_hi_ber),
    .o_phy_fault (o_phy_fault)
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmit-side scrambler, one bit at a time: y = d ^ y[n-39] ^ y[n-58].
  task automatic scramble(input logic [63:0] d, output logic [63:0] y);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b       = d[i] ^ tx_hist[38] ^ tx_hist[57];
      y[i]    = b;
      tx_hist = {tx_hist[56:0], b};
    end
  endtask

  task automatic send(input logic [1:0] hdr, input logic [63:0] pay, input bit expect_beat);
    logic [63:0] sc;
    scramble(pay, sc);
    i_valid = 1'b1;
    i_data  = {sc, hdr};
    if (expect_beat) exp_q.push_back({pay, hdr});
    wcnt++;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b0;
      i_data  = {2{33'h1_5A5A_A5A5}};
      @(negedge clk);
    end
  endtask

  // Alternating idle control blocks (type 0x1E) and data blocks.
  task automatic good_block(input int n, input bit expect_beat);
    for (int i = 0; i < n; i++) begin
      if (wcnt[0]) send(2'b01, (wcnt[1] ? {wcnt, ~wcnt} : 64'h0), expect_beat);
      else         send(2'b10, 64'h1E, expect_beat);
    end
  endtask

  task automatic bad_block(input int n, input bit expect_beat);
    for (int i = 0; i < n; i++) begin
      send(wcnt[0] ? 2'b11 : 2'b00, {~wcnt, wcnt}, expect_beat);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_slip"},   o_slip,       0);
    chk({tag, "_valid"},  rx_valid,     0);
    chk({tag, "_data"},   rx_data,      0);
    chk({tag, "_lock"},   o_block_lock, 0);
    chk({tag, "_hiber"},  o_hi_ber,     0);
    chk({tag, "_fault"},  o_phy_fault,  1);
  endtask

  // Scoreboard monitor.
  initial begin
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", rx_data, 66'h0);
          if (rx_data === 66'h0) begin
            n_fail++;
            $display("FAIL unexpected_beat: RX_VALID high with no expected word (t=%0t)", $time);
          end
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    // Acquire lock; an invalid cycle in the middle must not count.
    good_block(30, 0);
    idle(2);
    good_block(33, 0);
    chk("lock_after_63", o_block_lock, 0);
    chk("fault_before_lock", o_phy_fault, 1);
    good_block(1, 0);
    chk("lock_after_64", o_block_lock, 1);
    chk("fault_after_lock", o_phy_fault, 0);
    chk("no_valid_on_lock_word", rx_valid, 0);
    good_block(1, 1);
    chk("first_valid", rx_valid, 1);
    good_block(63, 1);

    // 15 bad headers in a window keep lock.
    bad_block(15, 1);
    good_block(49, 1);
    chk("lock_15_bad", o_block_lock, 1);
    chk("hiber_15_bad", o_hi_ber, 0);
    // 16th BER error overall raises hi-BER; 16th in this window drops lock.
    bad_block(1, 1);
    chk("hiber_16_bad", o_hi_ber, 1);
    chk("fault_hiber", o_phy_fault, 1);
    chk("lock_hiber", o_block_lock, 1);
    bad_block(14, 1);
    chk("lock_15_in_win", o_block_lock, 1);
    bad_block(1, 1);
    chk("unlock_16", o_block_lock, 0);
    chk("slip_on_unlock", o_slip, 1);
    chk("hiber_clr_unlock", o_hi_ber, 0);
    chk("fault_unlock", o_phy_fault, 1);
    chk("valid_last_beat", rx_valid, 1);

    // SLIPWAIT ignores exactly 32 words, then the next bad header slips.
    for (int i = 0; i < 32; i++) begin
      bad_block(1, 0);
      chk("slip_quiet", o_slip, 0);
    end
    chk("valid_dropped", rx_valid, 0);
    bad_block(1, 0);
    chk("slip_after_wait", o_slip, 1);
    bad_block(32, 0);
    good_block(63, 0);
    chk("relock_63", o_block_lock, 0);
    good_block(1, 0);
    chk("relock_64", o_block_lock, 1);

    // Four bad headers per window across four windows raise hi-BER, lock kept.
    for (int w = 0; w < 4; w++) begin
      bad_block(4, 1);
      if (w == 3) begin
        chk("hiber_spread", o_hi_ber, 1);
        chk("fault_spread", o_phy_fault, 1);
        chk("lock_spread", o_block_lock, 1);
      end else begin
        chk("hiber_spread_low", o_hi_ber, 0);
      end
      good_block(60, 1);
    end
    good_block(19531 - 256 - 1, 1);
    chk("hiber_before_end", o_hi_ber, 1);
    good_block(1, 1);
    chk("hiber_window_end", o_hi_ber, 1);
    good_block(19530, 1);
    chk("hiber_clean_pre", o_hi_ber, 1);
    good_block(1, 1);
    chk("hiber_clean_end", o_hi_ber, 0);
    chk("fault_clean_end", o_phy_fault, 0);

    // Asynchronous reset mid-packet with i_valid high.
    good_block(5, 1);
    i_valid = 1'b1;
    i_data  = {64'hFEED_FACE_0BAD_F00D, 2'b01};
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    good_block(63, 0);
    chk("reset_relock_63", o_block_lock, 0);
    good_block(1, 0);
    chk("reset_relock_64", o_block_lock, 1);
    good_block(8, 1);
    idle(2);
    chk("queue_drained", 66'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_blocklock_descrambler.md
Name: rx_blocklock_descrambler

Overview:
Receive-side 64b/66b front end, sitting between the GTX 66-bit raw output and the packet decoder. It acquires block lock by hunting for valid sync headers, commanding gearbox slips as needed. It self-synchronously descrambles the 64-bit payload and monitors header error rate. It delivers RX_VALID/RX_DATA and a PHY-fault flag to the 66-bit-to-packet stage.

Parameters:
LOCK_COUNT, 64, consecutive valid headers required to declare lock
WINDOW, 64, header window size while locked
BAD_LIMIT, 16, invalid headers within one WINDOW that force loss of lock
SLIP_WAIT, 32, valid input words ignored after each slip (GTX realign time)
BER_WINDOW, 19531, i_valid words per hi-BER measurement window (125 us at 156.25 MHz)
BER_LIMIT, 16, invalid headers per BER_WINDOW that raise hi-BER

Ports:
RX_CLK  in  1  receive clock
S_ARESETN  in  1  reset, asynchronous, active-low
i_valid  in  1  raw word valid from GTX gearbox
i_data  in  66  raw word; [1:0] sync header, [65:2] scrambled payload, bit 2 first on the wire
o_slip  out  1  one-cycle pulse requesting a 1-bit gearbox slip
RX_VALID  out  1  descrambled word valid (feeds packet decoder)
RX_DATA  out  66  {descrambled payload, received sync header}
o_block_lock  out  1  block lock achieved
o_hi_ber  out  1  header error rate above limit
o_phy_fault  out  1  !o_block_lock || o_hi_ber

Behaviour:
- Clock RX_CLK. Reset S_ARESETN is asynchronous and active-low. All state clears on reset.
- Reset values: o_slip=0, RX_VALID=0, RX_DATA=0, o_block_lock=0, o_hi_ber=0, o_phy_fault=1, descrambler state=0, FSM=HUNT, all counters=0.
- Header valid iff i_data[1:0] is 2'b01 or 2'b10. Headers 00 and 11 are invalid.
- Only cycles with i_valid=1 advance any counter, FSM, or descrambler state.
- FSM states: HUNT, SLIPWAIT, LOCKED.
  - HUNT, valid header: good_cnt++. When good_cnt reaches LOCK_COUNT, enter LOCKED, set o_block_lock=1, clear counters.
  - HUNT, invalid header: pulse o_slip for exactly one cycle, clear good_cnt, enter SLIPWAIT.
  - SLIPWAIT: count SLIP_WAIT i_valid words, ignoring their headers, then return to HUNT. o_slip never asserts in SLIPWAIT.
  - LOCKED: hdr_cnt counts every word; bad_cnt counts invalid headers.
  - LOCKED, bad_cnt reaches BAD_LIMIT before hdr_cnt reaches WINDOW: o_block_lock=0, pulse o_slip, enter SLIPWAIT. This takes effect on the same word that supplies the BAD_LIMIT-th error.
  - LOCKED, hdr_cnt reaches WINDOW with bad_cnt < BAD_LIMIT: clear both counters and stay LOCKED. If the final word of the window is also the BAD_LIMIT-th error, unlock wins.
- Descrambler (x^58 + x^39 + 1, self-synchronizing):
  - State s[57:0] holds the last 58 received scrambled bits, s[57] most recent.
  - Let p = i_data[65:2] and x = {p, s}.
  - Output bit k = p[k] ^ x[k+19] ^ x[k], for k = 0..63.
  - Next s = p[63:6].
  - The state updates on every i_valid word, locked or not, so it is synchronized by the time lock is declared.
- Output: one-cycle registered latency.
  - RX_VALID <= i_valid && LOCKED (as of the current FSM state, before that cycle's transition).
  - RX_DATA <= {descrambled payload, i_data[1:0]}.
  - Words carrying an invalid header while locked are passed through unaltered in [1:0]. The downstream stage treats them as non-data/non-control.
  - There is no backpressure: the downstream stage must accept every RX_VALID beat.
- Hi-BER monitor:
  - ber_timer counts i_valid words up to BER_WINDOW; ber_cnt counts invalid headers, saturating at BER_LIMIT.
  - At window end: o_hi_ber <= (ber_cnt >= BER_LIMIT), then both counters clear.
  - o_hi_ber also sets immediately when ber_cnt reaches BER_LIMIT mid-window.
  - The monitor runs only while o_block_lock=1. On loss of lock it clears o_hi_ber and both counters.
- o_phy_fault is registered, updates in the same cycle as o_block_lock/o_hi_ber, and reaches the downstream stage one cycle before any RX_VALID change caused by lock loss.
- Counter widths: ceil(log2(param+1)). No wrap-around may occur; every counter is cleared or saturated at its limit.

Test Plan:
- Reset release, then 64 scrambled words with alternating 01/10 headers -> o_block_lock=1 on the 64th word; first RX_VALID the next cycle; o_phy_fault 1->0.
- Scramble a known payload (idle blocks 0x1E plus zero data) with a matching-polynomial model; lock; feed -> RX_DATA equals the original payload from the first valid beat, since the descrambler is already primed.
- Bit-misaligned stream of 00/11 headers -> o_slip pulses once, then exactly SLIP_WAIT words pass before the next possible slip; after aligning input, lock occurs after 64 good headers.
- Locked; inject 15 bad headers in one 64-word window -> remains locked, counters clear at window end; inject 16 bad headers -> o_block_lock=0 and o_slip pulse on the 16th error; RX_VALID drops the following cycle.
- Locked; 16 bad headers spread over 4 windows (4 per window) within BER_WINDOW -> o_hi_ber=1, o_phy_fault=1, lock retained; next clean BER window -> o_hi_ber=0.
- Assert S_ARESETN low mid-packet with i_valid high -> all outputs take reset values asynchronously; relock requires a full 64 good headers.
